// File: rtl/recfn_to_fn_seq_if.sv
// Handshake bundle between a recoded-float producer and the recFN-to-fN converter.
// The master drives go/in_; the slave answers with out/done.
interface recfn_to_fn_seq_if #(
   parameter int expWidth = 8,
   parameter int sigWidth = 24
);
   logic                         go;
   logic [expWidth+sigWidth:0]   in_;
   logic [expWidth+sigWidth-1:0] out;
   logic                         done;

   modport master (output go, in_, input out, done);
   modport slave  (input go, in_, output out, done);
endinterface

// File: rtl/recfn_to_fn_seq.sv
// Sequential HardFloat recFN -> IEEE fN converter.
// Subnormals are denormalised by a 1-bit-per-cycle right shifter.
module recfn_to_fn_seq #(
   parameter int expWidth = 8,
   parameter int sigWidth = 24
) (
   input  logic           clk,
   input  logic           reset,
   recfn_to_fn_seq_if.slave bus
);
   localparam int W  = expWidth + sigWidth;
   localparam int CW = $clog2(sigWidth) + 1;
   localparam logic [31:0] MIN_NORM_I = 32'(2 ** (expWidth - 1) + 2);
   localparam logic [31:0] BIAS_I     = 32'(2 ** (expWidth - 1) + 1);
   localparam logic [31:0] SIGW_I     = 32'(sigWidth);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]          r_state;
   logic                r_sign;
   logic [sigWidth-1:0] r_sig;
   logic [CW-1:0]       r_cnt;
   logic [W-1:0]        r_out;

   logic                w_sign;
   logic [expWidth:0]   w_rec_exp;
   logic [sigWidth-2:0] w_fract;
   logic [2:0]          w_cls;
   logic                w_is_zero;
   logic                w_is_inf;
   logic                w_is_nan;
   logic                w_is_norm;
   logic [expWidth-1:0] w_exp_field;
   logic [expWidth:0]   w_sub_diff;
   logic [CW-1:0]       w_shift;
   logic [sigWidth-1:0] w_sig_sh;

   assign w_sign      = bus.in_[W];
   assign w_rec_exp   = bus.in_[W-1 -: expWidth+1];
   assign w_fract     = bus.in_[sigWidth-2:0];
   assign w_cls       = w_rec_exp[expWidth -: 3];
   assign w_is_zero   = (w_cls == 3'b000);
   assign w_is_inf    = (w_cls == 3'b110);
   assign w_is_nan    = (w_cls == 3'b111);
   assign w_is_norm   = !w_is_zero && !w_is_inf && !w_is_nan &&
                        (w_rec_exp >= MIN_NORM_I[expWidth:0]);
   // Modular subtraction gives the biased exponent directly in expWidth bits.
   assign w_exp_field = w_rec_exp[expWidth-1:0] - BIAS_I[expWidth-1:0];
   assign w_sub_diff  = MIN_NORM_I[expWidth:0] - w_rec_exp;
   assign w_shift     = (w_sub_diff >= SIGW_I[expWidth:0]) ? SIGW_I[CW-1:0]
                                                           : w_sub_diff[CW-1:0];
   assign w_sig_sh    = r_sig >> 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sign  <= 1'b0;
         r_sig   <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.go) begin
                  r_sign <= w_sign;
                  r_sig  <= {1'b1, w_fract};
                  r_cnt  <= w_shift;
                  if (w_is_zero) begin
                     r_out   <= {w_sign, {(W-1){1'b0}}};
                     r_state <= S_DONE;
                  end else if (w_is_inf) begin
                     r_out   <= {w_sign, {expWidth{1'b1}}, {(sigWidth-1){1'b0}}};
                     r_state <= S_DONE;
                  end else if (w_is_nan) begin
                     r_out   <= {w_sign, {expWidth{1'b1}}, w_fract};
                     r_state <= S_DONE;
                  end else if (w_is_norm) begin
                     r_out   <= {w_sign, w_exp_field, w_fract};
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               r_sig <= w_sig_sh;
               r_cnt <= r_cnt - CW'(1);
               // The edge that consumes the last count also publishes the result.
               if (r_cnt == CW'(1)) begin
                  r_out   <= {r_sign, {expWidth{1'b0}}, w_sig_sh[sigWidth-2:0]};
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.out  = r_out;
   assign bus.done = (r_state == S_DONE);
endmodule

// File: tb/tb_recfn_to_fn_seq.sv
// Scoreboard bench for recfn_to_fn_seq: a driver pushes expected results and done cycles,
// a negedge monitor pops and compares each time done is presented.
module tb_recfn_to_fn_seq;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   recfn_to_fn_seq_if #(.expWidth(8), .sigWidth(24)) bus ();

   recfn_to_fn_seq #(.expWidth(8), .sigWidth(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] v;
      int          at;
      int          tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_done actual=1 required=0 cyc=%0d", cyc);
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("out_%0d", mon_e.tag), bus.out, mon_e.v);
            check($sformatf("cycle_%0d", mon_e.tag), 32'(cyc), 32'(mon_e.at));
            $display("txn %0d out=%h expect=%h cyc=%0d", mon_e.tag, bus.out, mon_e.v, cyc);
         end
      end
   end

   // Reference: IEEE binary32 value -> leading-one position of a subnormal fraction.
   function automatic int msb23(input logic [22:0] m);
      int p = 0;
      for (int i = 0; i < 23; i++) if (m[i]) p = i;
      return p;
   endfunction

   // Reference recoder: recExp = unbiased exponent + 256 for finite nonzero values.
   function automatic logic [32:0] recode(input logic [31:0] f);
      logic [7:0]  e = f[30:23];
      logic [22:0] m = f[22:0];
      int p;
      if (e == 8'd0 && m == 23'd0) return {f[31], 32'd0};
      if (e == 8'hFF) return {f[31], (m == 23'd0) ? 9'h180 : 9'h1C0, m};
      if (e != 8'd0) return {f[31], {1'b0, e} + 9'd129, m};
      p = msb23(m);
      return {f[31], 9'(p + 107), 23'(m << (23 - p))};
   endfunction

   function automatic int extra_lat(input logic [31:0] f);
      if (f[30:23] == 8'd0 && f[22:0] != 23'd0) return 23 - msb23(f[22:0]);
      return 0;
   endfunction

   task automatic start(input logic [32:0] rin, input logic [31:0] ev, input int s, input int tag);
      exp_t e;
      bus.go  = 1'b1;
      bus.in_ = rin;
      e.v = ev; e.at = cyc + 1 + s; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      bus.go  = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string name);
      int k = 0;
      while (bus.done !== 1'b1 && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (bus.done !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout_%s actual=no_done required=done", name);
      end
   endtask

   task automatic convert(input logic [32:0] rin, input logic [31:0] ev, input int s, input int tag);
      start(rin, ev, s, tag);
      wait_done(s + 4, $sformatf("%0d", tag));
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] f;
      exp_t        e;
      int          nd;
      bus.go  = 1'b0;
      bus.in_ = '0;
      reset   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out", bus.out, 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // 1.0: done one cycle after the sampling edge, then held
      start(33'h080000000, 32'h3F800000, 0, 1);
      check("one_done_pulse", 32'(bus.done), 32'h1);
      @(negedge clk);
      check("one_done_low", 32'(bus.done), 32'h0);
      check("one_hold", bus.out, 32'h3F800000);

      convert(33'h0C0000000, 32'h7F800000, 0, 2);
      convert(33'h0E0400000, 32'h7FC00000, 0, 3);
      convert(33'h100000000, 32'h80000000, 0, 4);
      convert({1'b0, 9'd129, 23'h7FFFFE}, 32'h007FFFFF, 1, 5);
      convert({1'b0, 9'd107, 23'h000000}, 32'h00000001, 23, 6);
      convert({1'b1, 9'd64, 23'h001234}, 32'h80000000, 24, 7);

      // go pulse and in_ change while shifting are ignored
      start({1'b0, 9'd107, 23'h000000}, 32'h00000001, 23, 8);
      repeat (3) @(negedge clk);
      bus.go  = 1'b1;
      bus.in_ = 33'h080000000;
      @(negedge clk);
      bus.go  = 1'b0;
      bus.in_ = 33'(64'h1FFFFFFFF);
      wait_done(30, "8");
      @(negedge clk);

      // go held high across done: next conversion starts in the following IDLE cycle
      bus.go  = 1'b1;
      bus.in_ = {1'b0, 9'd129, 23'h7FFFFE};
      e.v = 32'h007FFFFF; e.at = cyc + 2; e.tag = 9;
      sb.push_back(e);
      @(negedge clk);
      wait_done(10, "9");
      bus.in_ = 33'h080000000;
      e.v = 32'h3F800000; e.at = cyc + 2; e.tag = 10;
      sb.push_back(e);
      @(negedge clk);
      @(negedge clk);
      bus.go = 1'b0;
      wait_done(4, "10");
      repeat (3) @(negedge clk);

      // reset during shift cycle 10 aborts the conversion
      start({1'b0, 9'd107, 23'h000000}, 32'h00000001, 23, 11);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_out", bus.out, 32'h0);
      check("abort_done", 32'(bus.done), 32'h0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done === 1'b1) nd++;
      end
      check("abort_no_done", 32'(nd), 32'h0);
      convert(33'h080000000, 32'h3F800000, 0, 12);

      for (int i = 0; i < 10000; i++) begin
         f = $urandom;
         if ($urandom_range(15) == 0) f[30:23] = 8'd0;
         convert(recode(f), f, extra_lat(f), 100 + i);
      end

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
